w_schedule_ctrl: RTL and testbench
==================================

Name: w_schedule_ctrl

Overview:
- Sequences SHA-256 message-schedule expansion for one 512-bit block at a time.
- Accepts a padded block over a valid/ready handshake and streams W0..W63, one word per accepted beat, to the compression-round engine.
- Holds a 16-word sliding window, so no 2048-bit W vector is stored.
- Supports downstream backpressure and a per-block completion pulse.

Parameters:
- W_LENGTH, 64, number of schedule words per block; fixed at 64 for SHA-256.
- WORD_W, 32, word width in bits.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- msg_valid  in  1  message_vector holds a padded block
- msg_ready  out  1  block accepted when msg_valid && msg_ready
- message_vector  in  512  block; W0 = bits [31:0], Wk = bits [32k+31:32k]
- w_valid  out  1  w_word and w_index are valid
- w_ready  in  1  downstream accepts the current word
- w_word  out  32  schedule word W[w_index]
- w_index  out  $clog2(W_LENGTH)  index 0..63
- block_done  out  1  one-cycle pulse after W63 is accepted
- busy  out  1  high from block acceptance through acceptance of W63

Behaviour:
- Reset (reset_n low, asynchronous):
  - State IDLE; window cleared.
  - msg_ready=1; w_valid=0; w_word=0; w_index=0; block_done=0; busy=0.
- IDLE:
  - msg_ready=1.
  - On msg_valid, load the window with W0..W15 from message_vector and go to STREAM with t=0.
  - Capture happens on the acceptance edge.
  - w_valid rises the next cycle: latency is 1 cycle from acceptance to W0 presented.
- STREAM:
  - msg_ready=0; busy=1; w_valid=1.
  - w_word = window[0] = W[t]; w_index = t.
  - Beat = w_valid && w_ready. On each beat:
    - shift the window down one word;
    - insert W[t+16] = σ1(W[t+14]) + W[t+9] + σ0(W[t+1]) + W[t], computed from the current window (positions 14, 9, 1, 0);
    - increment t.
  - With w_ready held high, one word is delivered per cycle and W0..W63 take 64 consecutive cycles.
  - When t=63 is accepted, go to DONE.
  - Window inserts for t ≥ 48 are don't-care; they may be computed but must not be visible.
- Arithmetic:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Combining is XOR, never addition.
  - All sums are modulo 2^32; carries are discarded.
- Backpressure:
  - w_ready low: w_word, w_index and the window hold, and w_valid stays high.
  - w_ready may toggle every cycle with no lost or duplicated words.
- DONE:
  - block_done=1 for exactly one cycle; w_valid=0; busy=0; msg_ready=0 that cycle.
  - Next cycle returns to IDLE.
  - A block is never accepted in the DONE cycle, so back-to-back blocks have a 2-cycle gap between W63 acceptance and the next W0.
- Boundary conditions:
  - msg_valid while busy is ignored; the block is not captured and msg_ready stays 0.
  - message_vector is sampled only on the acceptance edge; later changes have no effect.
  - reset_n asserted mid-block aborts immediately to reset values, with no block_done.
  - After reset release, the first edge may accept a block.
  - w_index never exceeds 63; t wraps only via the IDLE reload.

Decomposition:
- Shared package sha256_pkg holds:
  - WORD_W and W_LENGTH;
  - the state enum {IDLE, STREAM, DONE};
  - sigma0/sigma1 rotation constants (7,18,3 / 17,19,10).
- Sub-module w_sigma_unit: purely combinational.
  - Inputs: four window words.
  - Output: the new schedule word.
  - Reused later by the compression-round datapath.

Test Plan:
- Padded "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1:
  - W0 one cycle after acceptance; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6;
  - block_done exactly 1 cycle after W63 acceptance, with 64 beats in 64 cycles;
  - all 64 words match a reference model.
- Random w_ready at 50% on a random block:
  - the word sequence is identical to the w_ready=1 run;
  - w_word/w_index are stable while w_valid && !w_ready.
- msg_valid held high continuously with two different blocks:
  - second block accepted only in the IDLE cycle after block_done;
  - no capture during STREAM; the second stream is correct.
- reset_n pulsed low when w_index=30:
  - all outputs return to reset values asynchronously and no block_done occurs;
  - a following block streams correctly from W0.
- All-ones block (W0..W15=0xFFFFFFFF):
  - W16 = σ1(0xFFFFFFFF)+0xFFFFFFFF+σ0(0xFFFFFFFF)+0xFFFFFFFF mod 2^32, matching the model;
  - this checks carry discard and the XOR-vs-add distinction.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions.
// Word sizes, schedule FSM states, sigma constants.
package sha256_pkg;

  localparam int WORD_W   = 32;
  localparam int W_LENGTH = 64;
  localparam int IDX_W    = $clog2(W_LENGTH);
  localparam int WIN_LEN  = 16;

  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } sched_state_t;

  function automatic logic [WORD_W-1:0] rotr(
    input logic [WORD_W-1:0] x,
    input int                n
  );
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/w_sigma_unit.sv
// Message-schedule recurrence for one new word.
// W[t+16] from window taps 14, 9, 1 and 0.
module w_sigma_unit
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w_t14,
  input  logic [WORD_W-1:0] w_t9,
  input  logic [WORD_W-1:0] w_t1,
  input  logic [WORD_W-1:0] w_t0,
  output logic [WORD_W-1:0] w_new
);

  logic [WORD_W-1:0] sig0;
  logic [WORD_W-1:0] sig1;

  assign sig0 = rotr(w_t1, S0_R1)
              ^ rotr(w_t1, S0_R2)
              ^ (w_t1 >> S0_SH);

  assign sig1 = rotr(w_t14, S1_R1)
              ^ rotr(w_t14, S1_R2)
              ^ (w_t14 >> S1_SH);

  assign w_new = sig1 + w_t9 + sig0 + w_t0;

endmodule

// File: rtl/w_schedule_ctrl.sv
// SHA-256 message schedule sequencer.
// Streams W0..W63 from a 16-word sliding window.
module w_schedule_ctrl
  import sha256_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [WIN_LEN*WORD_W-1:0]  message_vector,
  output logic                       w_valid,
  input  logic                       w_ready,
  output logic [WORD_W-1:0]          w_word,
  output logic [IDX_W-1:0]           w_index,
  output logic                       block_done,
  output logic                       busy
);

  sched_state_t      state_q;
  sched_state_t      state_d;
  logic [IDX_W-1:0]  t_q;
  logic [WORD_W-1:0] win_q [WIN_LEN];
  logic [WORD_W-1:0] w_new;
  logic              accept;
  logic              beat;
  logic              last;

  assign accept = msg_valid && msg_ready;
  assign beat   = w_valid && w_ready;
  assign last   = (t_q == IDX_W'(W_LENGTH - 1));

  w_sigma_unit u_sigma (
    .w_t14 (win_q[14]),
    .w_t9  (win_q[9]),
    .w_t1  (win_q[1]),
    .w_t0  (win_q[0]),
    .w_new (w_new)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    msg_ready  = 1'b0;
    w_valid    = 1'b0;
    busy       = 1'b0;
    block_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_d = STREAM;
      end
      STREAM: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (w_ready && last) state_d = DONE;
      end
      DONE: begin
        block_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word index: cleared on load, advanced per beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t_q <= '0;
    end else if (accept) begin
      t_q <= '0;
    end else if (beat) begin
      t_q <= t_q + 1'b1;
    end
  end

  // Sliding window: block load or shift-and-insert
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        win_q[i] <= message_vector[i*WORD_W +: WORD_W];
      end
    end else if (beat) begin
      for (int i = 0; i < WIN_LEN - 1; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[WIN_LEN-1] <= w_new;
    end
  end

  assign w_word  = w_valid ? win_q[0] : '0;
  assign w_index = w_valid ? t_q : '0;

endmodule

// File: tb/tb_w_schedule_ctrl.sv
// Bench for w_schedule_ctrl.
// Random blocks and backpressure against an array model.
module tb_w_schedule_ctrl;

  logic         clock;
  logic         reset_n;
  logic         msg_valid;
  logic         msg_ready;
  logic [511:0] message_vector;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_word;
  logic [5:0]   w_index;
  logic         block_done;
  logic         busy;

  int n_assert;
  int n_fail;

  logic [31:0] exp_w   [64];
  logic [31:0] got_w   [64];
  logic [31:0] first_w [64];

  w_schedule_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .msg_valid      (msg_valid),
    .msg_ready      (msg_ready),
    .message_vector (message_vector),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_word         (w_word),
    .w_index        (w_index),
    .block_done     (block_done),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ror(
    input logic [31:0] x,
    input int          n
  );
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic void build_ref(input logic [511:0] b);
    for (int k = 0; k < 64; k++) begin
      if (k < 16) exp_w[k] = b[k*32 +: 32];
      else exp_w[k] = ssig1(exp_w[k-2]) + exp_w[k-7]
                    + ssig0(exp_w[k-15]) + exp_w[k-16];
    end
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; presents block and waits for acceptance.
  task automatic accept(input logic [511:0] b);
    int k;
    msg_valid      = 1'b1;
    message_vector = b;
    k = 0;
    while (!msg_ready && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    chk("accept_ready", 32'(msg_ready), 32'd1);
    @(posedge clock); #1;
    msg_valid      = 1'b0;
    message_vector = rand_block();
    chk("w0_latency_valid", 32'(w_valid), 32'd1);
    chk("w0_latency_index", 32'(w_index), 32'd0);
  endtask

  // Called #1 after the edge that presents W0; ends in IDLE.
  task automatic run_stream(input bit rnd);
    int          idx;
    int          cyc;
    bit          r;
    logic [31:0] pw;
    logic [5:0]  pi;
    idx = 0;
    cyc = 0;
    while (idx < 64 && cyc < 4000) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready = r;
      chk("w_valid", 32'(w_valid), 32'd1);
      chk("w_index", 32'(w_index), 32'(idx));
      chk("w_word", w_word, exp_w[idx]);
      chk("busy", 32'(busy), 32'd1);
      chk("msg_ready_stream", 32'(msg_ready), 32'd0);
      pw = w_word;
      pi = w_index;
      @(posedge clock); #1;
      cyc++;
      if (r) begin
        got_w[idx] = pw;
        idx++;
      end else begin
        chk("hold_word", w_word, pw);
        chk("hold_index", 32'(w_index), 32'(pi));
      end
    end
    if (idx < 64) chk("stream_timeout", 32'(idx), 32'd64);
    if (!rnd) chk("beats_cycles", 32'(cyc), 32'd64);
    w_ready = 1'b0;
    chk("done_pulse", 32'(block_done), 32'd1);
    chk("done_w_valid", 32'(w_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_msg_ready", 32'(msg_ready), 32'd0);
    @(posedge clock); #1;
    chk("done_single", 32'(block_done), 32'd0);
    chk("idle_msg_ready", 32'(msg_ready), 32'd1);
    chk("idle_w_valid", 32'(w_valid), 32'd0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_msg_ready"}, 32'(msg_ready), 32'd1);
    chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
    chk({tag, "_w_word"}, w_word, 32'd0);
    chk({tag, "_w_index"}, 32'(w_index), 32'd0);
    chk({tag, "_block_done"}, 32'(block_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [511:0] blk;
    logic [511:0] blk_b;
    int           k;
    int           nmis;
    n_assert       = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    msg_valid      = 1'b0;
    message_vector = '0;
    w_ready        = 1'b0;
    #3;
    reset_vals("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Padded "abc"
    blk = '0;
    blk[31:0]    = 32'h6162_6380;
    blk[511:480] = 32'h0000_0018;
    build_ref(blk);
    accept(blk);
    run_stream(1'b0);
    chk("abc_w16", got_w[16], 32'h6162_6380);
    chk("abc_w17", got_w[17], 32'h000F_0000);
    chk("abc_w18", got_w[18], 32'h7DA8_6405);
    chk("abc_w19", got_w[19], 32'h6000_03C6);

    // Random block, full rate then random backpressure
    blk = rand_block();
    build_ref(blk);
    accept(blk);
    run_stream(1'b0);
    for (int i = 0; i < 64; i++) first_w[i] = got_w[i];
    accept(blk);
    run_stream(1'b1);
    nmis = 0;
    for (int i = 0; i < 64; i++) if (got_w[i] !== first_w[i]) nmis++;
    chk("bp_seq_equal", 32'(nmis), 32'd0);

    // msg_valid held high across two blocks
    blk   = rand_block();
    blk_b = rand_block();
    msg_valid      = 1'b1;
    message_vector = blk;
    @(posedge clock); #1;
    chk("cont_a_w0", 32'(w_valid), 32'd1);
    message_vector = blk_b;
    build_ref(blk);
    run_stream(1'b0);
    @(posedge clock); #1;
    msg_valid      = 1'b0;
    message_vector = rand_block();
    chk("cont_b_valid", 32'(w_valid), 32'd1);
    chk("cont_b_index", 32'(w_index), 32'd0);
    build_ref(blk_b);
    run_stream(1'b0);

    // Reset mid-block at w_index 30
    blk = rand_block();
    build_ref(blk);
    accept(blk);
    w_ready = 1'b1;
    k = 0;
    while (w_index != 6'd30 && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    chk("rst_reach_30", 32'(w_index), 32'd30);
    chk("rst_word_30", w_word, exp_w[30]);
    #2 reset_n = 1'b0;
    #1;
    reset_vals("async_rst");
    w_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_vals("rst_held");
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_done", 32'(block_done), 32'd0);
    blk = rand_block();
    build_ref(blk);
    accept(blk);
    run_stream(1'b0);

    // All-ones block: carry discard and XOR combining
    blk = '1;
    build_ref(blk);
    chk("ones_model_w16", exp_w[16], 32'h203F_FFFC);
    accept(blk);
    run_stream(1'b0);
    chk("ones_w16", got_w[16], 32'h203F_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
